// File: rtl/seq_div16.sv
// -----------------------------------------------------------------------------
// seq_div16 -- 16-bit unsigned sequential restoring divider
//
// Accepts one division per start pulse while idle and produces the quotient
// and remainder after sixteen shift/trial-subtract steps. A zero divisor
// yields quotient 16'hFFFF, remainder = dividend and divByZero = 1.
//
// Configuration macro:
//   DIV_ZERO_FAST_EN  when defined, a zero divisor bypasses the sixteen
//                     iterations and goes straight from IDLE to DONE
//                     (busy is never raised for that request).
//
// Ports:
//   clk        in   1   clock, all state changes on the rising edge
//   rst        in   1   synchronous active-high reset
//   start      in   1   request pulse, honoured only while idle
//   dividend   in  16   unsigned dividend, captured with an accepted start
//   divisor    in  16   unsigned divisor, captured with an accepted start
//   quotient   out 16   registered quotient, held until the next result
//   remainder  out 16   registered remainder, held until the next result
//   busy       out  1   high while the iterations are running
//   done       out  1   one-cycle pulse when quotient/remainder are valid
//   divByZero  out  1   set with done for a zero divisor, cleared on accept
// -----------------------------------------------------------------------------
module seq_div16 (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [15:0] dividend,
    input  logic [15:0] divisor,
    output logic [15:0] quotient,
    output logic [15:0] remainder,
    output logic        busy,
    output logic        done,
    output logic        divByZero
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t      r_state;
    logic [16:0] r_prem;    // partial remainder
    logic [15:0] r_shq;     // dividend bits shift out of the top, quotient bits shift in at the bottom
    logic [15:0] r_dvs;     // captured divisor
    logic [4:0]  r_cnt;     // iterations still to perform
    logic        r_dz;      // captured divisor was zero
    logic [15:0] r_quo;
    logic [15:0] r_rem;
    logic        r_busy;
    logic        r_done;
    logic        r_dbz;

    logic [17:0] w_shifted;
    logic        w_fits;
    logic [16:0] w_sub;
    logic [16:0] w_next_prem;

    // One restoring step. The partial remainder is always below the divisor,
    // so the shifted value is below 2*divisor and a 17-bit difference is
    // exact whenever the trial subtraction fits.
    // NOTE: every always_comb output is assigned on every path, so no latch is inferred.
    always_comb begin
        w_shifted   = {r_prem, r_shq[15]};
        w_fits      = (w_shifted >= {2'b00, r_dvs});
        w_sub       = w_shifted[16:0] - {1'b0, r_dvs};
        w_next_prem = w_fits ? w_sub : w_shifted[16:0];
    end

    // done is the registered image of the DONE state: results are published
    // on the edge leaving DONE, so done and the new values appear together.
    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_prem  <= 17'd0;
            r_shq   <= 16'd0;
            r_dvs   <= 16'd0;
            r_cnt   <= 5'd0;
            r_dz    <= 1'b0;
            r_quo   <= 16'd0;
            r_rem   <= 16'd0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_dbz   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_dvs <= divisor;
                        r_dz  <= (divisor == 16'd0);
                        r_dbz <= 1'b0;
`ifdef DIV_ZERO_FAST_EN
                        if (divisor == 16'd0) begin
                            // Preload the answer the iterations would produce.
                            r_shq   <= 16'hFFFF;
                            r_prem  <= {1'b0, dividend};
                            r_cnt   <= 5'd0;
                            r_state <= S_DONE;
                        end else begin
                            r_shq   <= dividend;
                            r_prem  <= 17'd0;
                            r_cnt   <= 5'd16;
                            r_busy  <= 1'b1;
                            r_state <= S_RUN;
                        end
`else
                        r_shq   <= dividend;
                        r_prem  <= 17'd0;
                        r_cnt   <= 5'd16;
                        r_busy  <= 1'b1;
                        r_state <= S_RUN;
`endif
                    end
                end

                S_RUN: begin
                    r_prem <= w_next_prem;
                    r_shq  <= {r_shq[14:0], w_fits};
                    r_cnt  <= r_cnt - 5'd1;
                    if (r_cnt == 5'd1) begin
                        r_busy  <= 1'b0;
                        r_state <= S_DONE;
                    end
                end

                S_DONE: begin
                    r_quo   <= r_shq;
                    r_rem   <= r_prem[15:0];
                    r_dbz   <= r_dz;
                    r_done  <= 1'b1;
                    r_state <= S_IDLE;
                end

                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign quotient  = r_quo;
    assign remainder = r_rem;
    assign busy      = r_busy;
    assign done      = r_done;
    assign divByZero = r_dbz;

endmodule

// File: tb/tb_seq_div16.sv
// -----------------------------------------------------------------------------
// tb_seq_div16 -- self-checking bench for seq_div16
//
// Directed cases (known quotients, zero divisor, ignored re-start, reset in
// the middle of a run, reset beating start) followed by 1000 random divisions
// with nonzero divisors. Expected results come from plain integer / and %.
// Honours DIV_ZERO_FAST_EN for the zero-divisor latency.
// -----------------------------------------------------------------------------
module tb_seq_div16;

    logic        clk;
    logic        rst;
    logic        start;
    logic [15:0] dividend;
    logic [15:0] divisor;
    logic [15:0] quotient;
    logic [15:0] remainder;
    logic        busy;
    logic        done;
    logic        divByZero;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    // Last published results, used to verify outputs hold between done pulses.
    logic [15:0] last_q;
    logic [15:0] last_r;
    logic        last_dz;

    seq_div16 dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .dividend  (dividend),
        .divisor   (divisor),
        .quotient  (quotient),
        .remainder (remainder),
        .busy      (busy),
        .done      (done),
        .divByZero (divByZero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    // Advance one clock and settle just after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass = n_pass + 1;
        else begin
            n_fail = n_fail + 1;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One complete division. idx 0 is the first cycle after the accepting
    // edge, so a normal result shows done at idx 17.
    //   poke     : idx at which a one-cycle start with 50/5 is driven (-1 none)
    //   scramble : randomise operands every cycle while the division runs
    task automatic do_div(input string tag, input logic [15:0] a, input logic [15:0] b,
                          input int poke, input bit scramble);
        logic [15:0] eq;
        logic [15:0] er;
        logic        edz;
        int          exp_lat;
        int          exp_busy;
        int          idx;
        int          done_idx;
        int          busy_cnt;
        bit          held;

        if (b == 16'd0) begin
            eq  = 16'hFFFF;
            er  = a;
            edz = 1'b1;
        end else begin
            eq  = a / b;
            er  = a % b;
            edz = 1'b0;
        end
        exp_lat  = 17;
        exp_busy = 16;
`ifdef DIV_ZERO_FAST_EN
        if (b == 16'd0) begin
            exp_lat  = 1;
            exp_busy = 0;
        end
`endif

        dividend = a;
        divisor  = b;
        start    = 1'b1;
        tick();
        start    = 1'b0;

        idx      = 0;
        done_idx = -1;
        busy_cnt = 0;
        held     = 1'b1;
        while (done_idx < 0 && idx < 40) begin
            if (idx == 0 && last_dz)
                check({tag, " dbz_cleared"}, divByZero, 1'b0);
            if (busy)
                busy_cnt++;
            if (done) begin
                done_idx = idx;
            end else begin
                if (quotient !== last_q || remainder !== last_r)
                    held = 1'b0;
                if (scramble) begin
                    dividend = 16'($urandom);
                    divisor  = 16'($urandom);
                end
                if (idx == poke) begin
                    start    = 1'b1;
                    dividend = 16'd50;
                    divisor  = 16'd5;
                end else begin
                    start = 1'b0;
                end
                tick();
                idx++;
            end
        end
        start = 1'b0;

        check({tag, " latency"},   done_idx,  exp_lat);
        check({tag, " quotient"},  quotient,  eq);
        check({tag, " remainder"}, remainder, er);
        check({tag, " divByZero"}, divByZero, edz);
        check({tag, " busy_cycles"}, busy_cnt, exp_busy);
        check({tag, " held_before_done"}, held, 1'b1);

        tick();
        check({tag, " done_one_cycle"}, done, 1'b0);
        check({tag, " quotient_hold"},  quotient, eq);

        last_q  = eq;
        last_r  = er;
        last_dz = edz;
    endtask

    initial begin
        int          done_seen;
        logic [15:0] ra;
        logic [15:0] rb;

        rst      = 1'b1;
        start    = 1'b0;
        dividend = 16'd0;
        divisor  = 16'd0;
        last_q   = 16'd0;
        last_r   = 16'd0;
        last_dz  = 1'b0;

        // Reset state
        repeat (3) tick();
        check("reset quotient",  quotient,  16'd0);
        check("reset remainder", remainder, 16'd0);
        check("reset busy",      busy,      1'b0);
        check("reset done",      done,      1'b0);
        check("reset divByZero", divByZero, 1'b0);
        rst = 1'b0;
        tick();

        // Directed divisions
        do_div("d100_7",     16'd100,   16'd7,  -1, 1'b0);
        do_div("dffff_1",    16'hFFFF,  16'd1,  -1, 1'b0);
        do_div("d5_9",       16'd5,     16'd9,  -1, 1'b0);
        do_div("d0_13",      16'd0,     16'd13, -1, 1'b0);
        do_div("dffff_ffff", 16'hFFFF,  16'hFFFF, -1, 1'b0);
        do_div("d1234_0",    16'd1234,  16'd0,  -1, 1'b0);
        do_div("d1000_10_repulse", 16'd1000, 16'd10, 4, 1'b0);

        // Reset in the eighth RUN cycle
        dividend = 16'd60000;
        divisor  = 16'd3;
        start    = 1'b1;
        tick();
        start    = 1'b0;
        repeat (7) tick();
        check("midrun busy_before_rst", busy, 1'b1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midrun_rst quotient",  quotient,  16'd0);
        check("midrun_rst remainder", remainder, 16'd0);
        check("midrun_rst busy",      busy,      1'b0);
        check("midrun_rst done",      done,      1'b0);
        check("midrun_rst divByZero", divByZero, 1'b0);
        done_seen = 0;
        repeat (20) begin
            tick();
            if (done || busy)
                done_seen++;
        end
        check("midrun_rst stays_idle", done_seen, 0);
        last_q  = 16'd0;
        last_r  = 16'd0;
        last_dz = 1'b0;

        // Reset wins over start in the same cycle
        rst      = 1'b1;
        start    = 1'b1;
        dividend = 16'd77;
        divisor  = 16'd7;
        tick();
        rst   = 1'b0;
        start = 1'b0;
        check("rst_vs_start busy", busy, 1'b0);
        done_seen = 0;
        repeat (20) begin
            tick();
            if (done || busy)
                done_seen++;
        end
        check("rst_vs_start no_division", done_seen, 0);
        check("rst_vs_start quotient",    quotient,  16'd0);

        do_div("d9_4_after_rst", 16'd9, 16'd4, -1, 1'b0);

        // Random operand pairs with nonzero divisors, operands scrambled mid-run
        for (int i = 0; i < 1000; i++) begin
            ra = 16'($urandom);
            if (i % 4 == 0)
                rb = 16'($urandom_range(1, 15));
            else
                rb = 16'($urandom_range(1, 65535));
            do_div("random", ra, rb, -1, 1'b1);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
